fpnew_result_rob: RTL

- In-order writeback buffer placed directly downstream of the FPU top.
- The FPU returns results out of order: op groups have different latencies and share a round-robin output arbiter.
- This block hands out a slot ID at issue; the core uses that ID as the FPU tag. The block captures completions by tag and retires results strictly in allocation order.
- It also keeps sticky accumulated fflags for the retired results.

---
 rtl/fpnew_result_rob.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fpnew_result_rob.sv
// fpnew_result_rob: in-order writeback buffer placed after the FPU.
// Hands out a slot ID at issue. The core uses that ID as the FPU tag.
// Completions that arrive out of order are captured by tag. Results retire
// strictly in allocation order. Sticky fflags are accumulated for retired ops.
//
// Handshakes: each channel transfers on a cycle where valid and ready are both
// high at the rising clock edge. alloc_ready_o and wb_valid_o depend only on
// registers, never on the partner's valid/ready. cpl_ready_o is tied high
// because every completion already owns a reserved slot.
module fpnew_result_rob #(
    parameter int unsigned Width   = 64,
    parameter int unsigned Depth   = 4,     // power of two, >= 2
    localparam int unsigned IdWidth = $clog2(Depth)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               alloc_valid_i,
    output logic               alloc_ready_o,
    output logic [IdWidth-1:0] alloc_id_o,
    input  logic               cpl_valid_i,
    output logic               cpl_ready_o,
    input  logic [IdWidth-1:0] cpl_id_i,
    input  logic [Width-1:0]   cpl_result_i,
    input  logic [4:0]         cpl_status_i,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [IdWidth-1:0] wb_id_o,
    output logic [Width-1:0]   wb_result_o,
    output logic [4:0]         wb_status_o,
    output logic [4:0]         fflags_o,
    input  logic               fflags_clr_i,
    output logic [IdWidth:0]   count_o,
    output logic               err_o
);

    localparam logic [IdWidth:0] DepthCnt = (IdWidth+1)'(Depth);

    // Pointer and occupancy state
    logic [IdWidth-1:0] head_q;
    logic [IdWidth-1:0] tail_q;
    logic [IdWidth:0]   count_q;

    // Per-slot bookkeeping and payload
    logic [Depth-1:0]   alloc_q;
    logic [Depth-1:0]   done_q;
    logic [Width-1:0]   result_q [Depth];
    logic [4:0]         status_q [Depth];

    logic [4:0]         fflags_q;
    logic               err_q;

    // Handshake qualifiers; flush overrides every other event in its cycle
    logic alloc_fire;
    logic cpl_ok;
    logic cpl_fire;
    logic cpl_bad;
    logic retire_fire;

    // Ready/valid derived from registered state only; a full buffer cannot
    // reuse a slot that is being retired in the same cycle.
    always_comb begin
        alloc_ready_o = (count_q < DepthCnt);
        wb_valid_o    = alloc_q[head_q] & done_q[head_q];
        alloc_fire    = alloc_valid_i & alloc_ready_o & ~flush_i;
        cpl_ok        = alloc_q[cpl_id_i] & ~done_q[cpl_id_i];
        cpl_fire      = cpl_valid_i & cpl_ok & ~flush_i;
        cpl_bad       = cpl_valid_i & ~cpl_ok & ~flush_i;
        retire_fire   = wb_valid_o & wb_ready_i & ~flush_i;
    end

    // Control state: pointers, count, per-slot flags and the error pulse
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= cpl_bad;
            // Retire is applied before alloc. The two can only hit the same
            // slot when the buffer is full, and alloc is blocked then.
            if (retire_fire) begin
                alloc_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                head_q          <= head_q + IdWidth'(1);
            end
            if (alloc_fire) begin
                alloc_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + IdWidth'(1);
            end
            // A completing slot is never the retiring slot (done is still 0)
            // nor the allocating slot (alloc is still 0).
            if (cpl_fire) begin
                done_q[cpl_id_i] <= 1'b1;
            end
            count_q <= count_q + (IdWidth+1)'(alloc_fire) - (IdWidth+1)'(retire_fire);
        end
    end

    // Payload capture; storage is deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (cpl_fire) begin
            result_q[cpl_id_i] <= cpl_result_i;
            status_q[cpl_id_i] <= cpl_status_i;
        end
    end

    // Sticky flags: clear takes effect first, then the retiring status is ORed
    // in. A flush keeps the accumulated flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fflags_q <= '0;
        end else if (retire_fire) begin
            fflags_q <= (fflags_clr_i ? 5'b0 : fflags_q) | status_q[head_q];
        end else if (fflags_clr_i) begin
            fflags_q <= '0;
        end
    end

    assign alloc_id_o  = tail_q;
    assign cpl_ready_o = 1'b1;
    assign wb_id_o     = head_q;
    assign wb_result_o = result_q[head_q];
    assign wb_status_o = status_q[head_q];
    assign fflags_o    = fflags_q;
    assign count_o     = count_q;
    assign err_o       = err_q;

endmodule
